// File: rtl/macc_seq_ctrl.sv
`timescale 1ns/1ps
// macc_seq_ctrl
// Sequencer for one MACC instance. Accepts a dot-product command, streams
// operand beats into the MACC with the right op_code per beat, waits out the
// MACC pipeline latency, captures the final MACC output and offers it on a
// result port.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   cmd_*                 command channel (len, square, bias enable, bias)
//   op_valid/op_ready     operand beat channel, op_a/op_b operands
//   macc_*                registered drive to the MACC, macc_out is its result
//   res_valid/res_ready   result channel, res_data is the captured macc_out
//   busy                  high whenever the sequencer is not idle
//   dbg_state             current FSM state (IDLE=0, STREAM=1, DRAIN=2, DONE=3)
//
// Handshakes: every channel transfers in a cycle where both valid and ready
// are high at the rising edge. Ready never depends on the same-cycle valid
// of that channel; it is a function of the FSM state only.
module macc_seq_ctrl #(
    parameter int OP_WIDTH     = 16,
    parameter int ACC_WIDTH    = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int LEN_WIDTH    = 10,
    parameter int MACC_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic                 cmd_square,
    input  logic                 cmd_bias_en,
    input  logic [ACC_WIDTH-1:0] cmd_bias,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [OP_WIDTH-1:0]  op_a,
    input  logic [OP_WIDTH-1:0]  op_b,
    output logic                 macc_enable,
    output logic                 macc_clear,
    output logic [2:0]           macc_op_code,
    output logic [OP_WIDTH-1:0]  macc_op_0,
    output logic [OP_WIDTH-1:0]  macc_op_1,
    output logic [ACC_WIDTH-1:0] macc_op_add,
    input  logic [OUT_WIDTH-1:0] macc_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OUT_WIDTH-1:0] res_data,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam int DRAIN_W = (MACC_LATENCY < 1) ? 1 : $clog2(MACC_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 square_q, square_d;
    logic                 bias_en_q, bias_en_d;
    logic [ACC_WIDTH-1:0] bias_q, bias_d;
    logic                 zero_q, zero_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [OUT_WIDTH-1:0] res_data_q, res_data_d;

    logic                 enable_q, enable_d;
    logic                 clear_q, clear_d;
    logic [2:0]           op_code_q, op_code_d;
    logic [OP_WIDTH-1:0]  op_0_q, op_0_d;
    logic [OP_WIDTH-1:0]  op_1_q, op_1_d;
    logic [ACC_WIDTH-1:0] op_add_q, op_add_d;

    // Beat issued to the MACC this cycle (external or the internal zero beat).
    logic                 beat_fire;
    logic [OP_WIDTH-1:0]  beat_a;
    logic [OP_WIDTH-1:0]  beat_b;
    logic [LEN_WIDTH-1:0] beat_next;

    assign beat_next = beat_cnt_q + LEN_WIDTH'(1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        square_d    = square_q;
        bias_en_d   = bias_en_q;
        bias_d      = bias_q;
        zero_d      = zero_q;
        drain_cnt_d = drain_cnt_q;
        res_data_d  = res_data_q;
        beat_fire   = 1'b0;
        beat_a      = op_a;
        beat_b      = op_b;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    len_d      = cmd_len;
                    square_d   = cmd_square;
                    bias_en_d  = cmd_bias_en;
                    bias_d     = cmd_bias;
                    beat_cnt_d = '0;
                    zero_d     = (cmd_len == '0);
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (zero_q) begin
                    // A zero-length command still needs one MACC update so
                    // the result reflects the bias (or 0) and not stale data.
                    beat_fire   = 1'b1;
                    beat_a      = '0;
                    beat_b      = '0;
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_W'(MACC_LATENCY);
                end else if (op_valid) begin
                    beat_fire  = 1'b1;
                    beat_cnt_d = beat_next;
                    if (beat_next == len_q) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_W'(MACC_LATENCY);
                    end
                end
            end
            ST_DRAIN: begin
                // Counter hits 0 exactly in the cycle the last beat's result
                // is visible on macc_out.
                if (drain_cnt_q == '0) begin
                    res_data_d = macc_out;
                    state_d    = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // MACC drive: op_code and operands hold through gaps so a stalled
        // stream does not disturb accumulation.
        enable_d  = beat_fire;
        op_code_d = op_code_q;
        op_0_d    = op_0_q;
        op_1_d    = op_1_q;
        op_add_d  = op_add_q;
        if (beat_fire) begin
            op_0_d   = beat_a;
            op_1_d   = square_q ? beat_a : beat_b;
            op_add_d = bias_q;
            if (beat_cnt_q == '0) begin
                op_code_d = {bias_en_q, 1'b0, square_q};
            end else begin
                op_code_d = {1'b0, 1'b1, square_q};
            end
        end
        clear_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            square_q    <= 1'b0;
            bias_en_q   <= 1'b0;
            bias_q      <= '0;
            zero_q      <= 1'b0;
            drain_cnt_q <= '0;
            res_data_q  <= '0;
            enable_q    <= 1'b0;
            clear_q     <= 1'b1;
            op_code_q   <= 3'd0;
            op_0_q      <= '0;
            op_1_q      <= '0;
            op_add_q    <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            square_q    <= square_d;
            bias_en_q   <= bias_en_d;
            bias_q      <= bias_d;
            zero_q      <= zero_d;
            drain_cnt_q <= drain_cnt_d;
            res_data_q  <= res_data_d;
            enable_q    <= enable_d;
            clear_q     <= clear_d;
            op_code_q   <= op_code_d;
            op_0_q      <= op_0_d;
            op_1_q      <= op_1_d;
            op_add_q    <= op_add_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign op_ready     = (state_q == ST_STREAM) && !zero_q;
    assign res_valid    = (state_q == ST_DONE);
    assign res_data     = res_data_q;
    assign busy         = (state_q != ST_IDLE);
    assign dbg_state    = state_q;
    assign macc_enable  = enable_q;
    assign macc_clear   = clear_q;
    assign macc_op_code = op_code_q;
    assign macc_op_0    = op_0_q;
    assign macc_op_1    = op_1_q;
    assign macc_op_add  = op_add_q;

endmodule

// File: tb/tb_macc_seq_ctrl.sv
`timescale 1ns/1ps
module tb_macc_seq_ctrl;
  localparam int OPW  = 16;
  localparam int ACCW = 16;
  localparam int OUTW = 16;
  localparam int LENW = 10;
  localparam int LAT  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [LENW-1:0] cmd_len = '0;
  logic            cmd_square = 1'b0;
  logic            cmd_bias_en = 1'b0;
  logic [ACCW-1:0] cmd_bias = '0;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [OPW-1:0]  op_a = '0;
  logic [OPW-1:0]  op_b = '0;
  logic            macc_enable;
  logic            macc_clear;
  logic [2:0]      macc_op_code;
  logic [OPW-1:0]  macc_op_0;
  logic [OPW-1:0]  macc_op_1;
  logic [ACCW-1:0] macc_op_add;
  logic [OUTW-1:0] macc_out = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [OUTW-1:0] res_data;
  logic            busy;
  logic [1:0]      dbg_state;

  macc_seq_ctrl #(
    .OP_WIDTH(OPW), .ACC_WIDTH(ACCW), .OUT_WIDTH(OUTW),
    .LEN_WIDTH(LENW), .MACC_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_square(cmd_square), .cmd_bias_en(cmd_bias_en), .cmd_bias(cmd_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .macc_enable(macc_enable), .macc_clear(macc_clear), .macc_op_code(macc_op_code),
    .macc_op_0(macc_op_0), .macc_op_1(macc_op_1), .macc_op_add(macc_op_add),
    .macc_out(macc_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Q1.15 fixed-point multiply, truncated to the operand width.
  function automatic logic [15:0] fx_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[30:15];
  endfunction

  // ---------------- MACC environment model ----------------
  // op_code bit2: add op_add, bit1: accumulate previous value, bit0: square
  // (square is already reflected in the operands). Result visible LAT cycles
  // after the enable cycle.
  logic [OUTW-1:0] m_acc = '0;
  logic [OUTW-1:0] m_nv;
  logic [OUTW-1:0] m_s1 = '0, m_s2 = '0;
  logic            m_v1 = 1'b0, m_v2 = 1'b0;

  always_comb begin
    m_nv = fx_mul(macc_op_0, macc_op_1);
    if (macc_op_code[1]) m_nv = m_nv + m_acc;
    if (macc_op_code[2]) m_nv = m_nv + macc_op_add;
  end

  always @(posedge clk) begin
    if (macc_enable) begin
      m_acc <= m_nv;
      m_s1  <= m_nv;
    end
    m_v1 <= macc_enable;
    m_s2 <= m_s1;
    m_v2 <= m_v1;
    if (m_v2) macc_out <= m_s2;
  end

  // ---------------- scoreboard ----------------
  // Expected MACC drive per beat: {op_0, op_1, op_code, op_add}.
  logic [50:0] exp_q[$];
  logic [2:0]  prev_code = 3'd0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (reset && macc_enable) begin
      if (exp_q.size() == 0) check_eq("extra_beat", 64'd1, 64'd0);
      else check_eq("beat", {macc_op_0, macc_op_1, macc_op_code, macc_op_add}, exp_q.pop_front());
    end
    if (reset && !macc_enable && prev_valid) check_eq("code_hold", macc_op_code, prev_code);
    prev_code  <= macc_op_code;
    prev_valid <= reset;
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    check_eq({tag, "_clear"}, macc_clear, 1);
    check_eq({tag, "_op_ready"}, op_ready, 0);
    check_eq({tag, "_enable"}, macc_enable, 0);
    check_eq({tag, "_op_code"}, macc_op_code, 0);
    check_eq({tag, "_ops"}, {macc_op_0, macc_op_1, macc_op_add}, 0);
    check_eq({tag, "_res_valid"}, res_valid, 0);
    check_eq({tag, "_res_data"}, res_data, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // vmode: 0 random op_valid, 1 toggling 1,0,1,0..., 2 always valid.
  task automatic run_cmd(input int len, input bit sq, input bit ben, input logic [15:0] bias,
                         input int vmode, input int hold, input bit fixed,
                         input logic [15:0] fa, input logic [15:0] fb,
                         output logic [15:0] result);
    logic [15:0] a, b, b_eff, ref_v, rd;
    int beats, tl, c, guard, opr_seen;
    ref_v = ben ? bias : 16'h0;
    result = 16'h0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_len = LENW'(len); cmd_square = sq;
    cmd_bias_en = ben; cmd_bias = bias;
    @(negedge clk);
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    check_eq("cmd_accept", cmd_ready, 1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    c = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_len = LENW'($urandom); cmd_bias = 16'($urandom);
    if (len == 0) exp_q.push_back({16'h0, 16'h0, ben, 1'b0, sq, bias});
    beats = 0; tl = -1; guard = 0;
    while (beats < len && guard < 2000) begin
      a = fixed ? fa : 16'($urandom);
      b = fixed ? fb : 16'($urandom);
      op_a = a; op_b = b;
      op_valid = (vmode == 0) ? 1'($urandom_range(0, 1)) : (vmode == 1) ? (guard % 2 == 0) : 1'b1;
      @(negedge clk);
      if (op_valid && op_ready) begin
        b_eff = sq ? a : b;
        exp_q.push_back({a, b_eff, (beats == 0) ? {ben, 1'b0, sq} : {1'b0, 1'b1, sq}, bias});
        ref_v = ref_v + fx_mul(a, b_eff);
        beats++;
        tl = cyc;
      end
      guard++;
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    check_eq("beat_count", beats, len);
    @(negedge clk);
    guard = 0; opr_seen = 0;
    while (!res_valid && guard < 100) begin
      if (op_ready) opr_seen++;
      @(negedge clk); guard++;
    end
    check_eq("res_valid_seen", res_valid, 1);
    if (len == 0) begin
      check_eq("zero_op_ready", opr_seen, 0);
      check_eq("res_latency", cyc, c + 6);
    end else begin
      check_eq("res_latency", cyc, tl + 5);
    end
    check_eq("res_data", res_data, ref_v);
    rd = res_data;
    result = rd;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; res_ready = 1'b0;
      @(negedge clk);
      check_eq("hold_res_data", res_data, rd);
      check_eq("hold_res_valid", res_valid, 1);
      check_eq("hold_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check_eq("hs_res_valid", res_valid, 1);
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check_eq("post_hs_cmd_ready", cmd_ready, 1);
    check_eq("post_hs_busy", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] r;
    int rv_seen;
    logic [15:0] a0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("init");
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset in the middle of a len=8 stream.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_len = 10'd8; cmd_square = 1'b0; cmd_bias_en = 1'b0; cmd_bias = 16'h0;
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a0 = 16'($urandom);
      op_valid = 1'b1; op_a = a0; op_b = 16'h1234;
      @(negedge clk);
      check_eq("rst_op_ready", op_ready, 1);
      if (op_ready) exp_q.push_back({a0, 16'h1234, (i == 0) ? 3'd0 : 3'd2, 16'h0});
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid || busy) rv_seen++;
    end
    check_eq("rst_no_result", rv_seen, 0);
    check_eq("rst_queue_empty", exp_q.size(), 0);

    // len=1, 0.5*0.5 with no bias.
    run_cmd(1, 1'b0, 1'b0, 16'h0, 2, 0, 1'b1, 16'h4000, 16'h4000, r);
    check_eq("half_squared", r, 16'h2000);
    // len=4 with toggling op_valid.
    run_cmd(4, 1'b0, 1'b0, 16'h0, 1, 0, 1'b0, 16'h0, 16'h0, r);
    // len=3, square mode with bias.
    run_cmd(3, 1'b1, 1'b1, 16'h0100, 2, 0, 1'b0, 16'h0, 16'h0, r);
    // len=0 with bias: internal zero beat only.
    run_cmd(0, 1'b0, 1'b1, 16'h1234, 2, 0, 1'b0, 16'h0, 16'h0, r);
    check_eq("zero_len_bias", r, 16'h1234);
    // Result held while the consumer stalls for 10 cycles.
    run_cmd(5, 1'b0, 1'b1, 16'h0042, 0, 10, 1'b0, 16'h0, 16'h0, r);

    for (int n = 0; n < 16; n++) begin
      run_cmd($urandom_range(0, 10), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
              1'b0, 16'h0, 16'h0, r);
    end

    repeat (4) @(posedge clk);
    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/macc_seq_ctrl.md
# macc_seq_ctrl

Command-driven sequencer for one `macc` instance. It accepts a dot-product command (length, square mode, optional bias), streams operand pairs into the MACC, and drives `enable`, `op_code`, `clear` and `op_add` with correct pipeline alignment. It waits out the MACC latency, captures the final `out` into a holding register, and presents it on a valid/ready result port. It sits between the PE operand buffers and the MACC in each processing element.

## Interface
- `OP_WIDTH`, default 16: operand width; equals the MACC `OP_0_WIDTH`/`OP_1_WIDTH`.
- `ACC_WIDTH`, default 16: bias width; equals the MACC `ACC_WIDTH`.
- `OUT_WIDTH`, default 16: result width; equals the MACC `OUT_WIDTH`.
- `LEN_WIDTH`, default 10: width of the vector-length field.
- `MACC_LATENCY`, default 3: cycles from `macc_enable` high to an updated `macc_out`.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-low reset; `reset`=0 at a rising edge resets the block.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted when this and `cmd_valid` are both high.
- `cmd_len`  in  LEN_WIDTH  number of operand beats; 0 is legal.
- `cmd_square`  in  1  1 = square mode (`op_code[0]`=1); `op_b` is ignored.
- `cmd_bias_en`  in  1  1 = add `cmd_bias` on the first beat.
- `cmd_bias`  in  ACC_WIDTH  bias value.
- `op_valid`  in  1  operand beat valid.
- `op_ready`  out  1  operand beat accepted when this and `op_valid` are both high.
- `op_a`, `op_b`  in  OP_WIDTH  operands.
- `macc_enable`  out  1  to MACC `enable`.
- `macc_clear`  out  1  to MACC `clear`.
- `macc_op_code`  out  3  to MACC `op_code`.
- `macc_op_0`, `macc_op_1`  out  OP_WIDTH  to MACC operands.
- `macc_op_add`  out  ACC_WIDTH  to MACC `op_add`.
- `macc_out`  in  OUT_WIDTH  from MACC `out`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result consumer ready.
- `res_data`  out  OUT_WIDTH  captured result.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, STREAM, DRAIN, DONE. Reset enters IDLE.
- **IDLE:**
  - `cmd_ready`=1 and `macc_clear`=1.
  - On accept, latch `cmd_len`, `cmd_square`, `cmd_bias_en` and `cmd_bias`, and clear the beat counter.
  - If `cmd_len`≠0, go to STREAM.
  - If `cmd_len`=0, go to STREAM in zero-beat mode.
- **STREAM:**
  - `op_ready`=1. `macc_clear`=0.
  - Each accepted beat increments the beat counter. When the count reaches `cmd_len`, go to DRAIN.
  - Zero-beat mode: `op_ready`=0. The block injects one internal beat with both operands 0 in its first STREAM cycle, then goes to DRAIN.
- **MACC drive:** all `macc_*` outputs are registered. For a beat accepted in cycle t, the following values appear in cycle t+1:
  - `macc_enable`=1.
  - `macc_op_0`=`op_a`.
  - `macc_op_1`=`op_b`, or `op_a` when square mode is set.
  - `macc_op_add`=latched bias.
  - `macc_op_code`:
    - first beat with bias: {1,0,sq}
    - first beat without bias: {0,0,sq}
    - later beats: {0,1,sq}
  - In any cycle with no beat accepted, `macc_enable`=0 and the previous `macc_op_code` is held. A gap in `op_valid` therefore does not disturb accumulation.
- **DRAIN:**
  - `op_ready`=0. A down-counter is loaded with `MACC_LATENCY` on entry.
  - When the counter reaches 0, `res_data`<=`macc_out`, then go to DONE.
- **DONE:**
  - `res_valid`=1 and `res_data` is held stable.
  - On `res_ready`=1, go to IDLE.
- **Result handling:** `res_data` is never reinterpreted; it is a copy of MACC `out`.
- **Reset mid-operation:** from any state, the block returns to IDLE. All `macc_*` outputs go to 0, except `macc_clear`=1. Any pending beats and result are discarded.

## Timing
- Reset values:
  - `cmd_ready`=1, `macc_clear`=1.
  - `op_ready`=0, `macc_enable`=0, `macc_op_code`=0, `macc_op_0`/`macc_op_1`/`macc_op_add`=0.
  - `res_valid`=0, `res_data`=0, `busy`=0.
- Command accepted in cycle c → STREAM from c+1. The earliest first beat is in cycle c+1.
- `macc_clear` drops in cycle c+1. Because MACC `clear` is delayed 2 cycles, it resolves before the first `out_reg` write.
- Last beat accepted in cycle tL:
  - `macc_enable` is high in tL+1.
  - `macc_out` is updated in tL+1+`MACC_LATENCY`.
  - `res_data` is captured at the end of that cycle.
  - `res_valid`=1 from tL+5 (with default latency).
- Zero-length command: the internal beat is issued in cycle c+1 → `res_valid` from c+6.
- `res_valid` and `res_ready` high in the same cycle → IDLE next cycle, so `cmd_ready` is back at 1 one cycle after the handshake.
- `cmd_valid` while not IDLE: ignored (`cmd_ready`=0). Back-to-back command throughput is len+6 cycles minimum.

## Test plan
- Reset held low for 3 cycles during STREAM of a len=8 command → all outputs at reset values; no `res_valid`; a following new command completes normally.
- len=1, `op_a`=`op_b`=0x4000, no bias, not square → `macc_op_code`=0 for one cycle; `res_data`=0x2000; `res_valid` exactly 5 cycles after the beat.
- len=4 with `op_valid` toggling 1,0,1,0,… → `macc_op_code` sequence 0,2,2,2 on enabled cycles only; `res_data` equals the MACC model output sampled 3 cycles after the last enable.
- len=3, square, bias=0x0100 → `op_code` sequence 5,3,3; `macc_op_1` mirrors `op_a`; `macc_op_add`=0x0100.
- len=0 with bias → one internal zero beat with `op_code` 4; `op_ready` never asserted; `res_valid` at c+6.
- `res_ready` held 0 for 10 cycles → `res_data` is stable, `cmd_ready`=0 and `cmd_valid` is ignored; the next command is accepted one cycle after `res_ready` rises.
